// File: rtl/csb_pkg.sv
// Shared types for the CSB transaction tracker: forwarded request bundle,
// queue entry layout, FSM state encoding and the default timeout reply word.
package csb_pkg;

    localparam int unsigned CSB_ID_WIDTH = 1;
    localparam logic [31:0] CSB_ERR_DATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] wdat;
        logic        write;
        logic        nposted;
    } csb_req_t;

    // Default-width entry; the tracker re-declares it with its own ID_WIDTH.
    typedef struct packed {
        logic [CSB_ID_WIDTH-1:0] id;
        logic                    is_write;
    } trk_entry_t;

    typedef enum logic {
        TRK_RUN  = 1'b0,
        TRK_HALT = 1'b1
    } trk_state_e;

endpackage

// File: rtl/csb_id_fifo.sv
// In-order queue of outstanding response entries. Pointers carry one extra
// wrap bit so full and empty are distinguishable; push is allowed when full if a pop accompanies it.
module csb_id_fifo #(
    parameter int WIDTH = $bits(csb_pkg::trk_entry_t),
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/csb_txn_tracker.sv
// Forwards CSB requests to NVDLA and tags returning responses with the periph
// ID of the oldest outstanding request; a watchdog converts lost responses into error replies.
//
// state | meaning
// RUN   | requests forwarded, NVDLA responses popped and answered
// HALT  | watchdog fired: requests blocked, remaining entries time out, late responses dropped
module csb_txn_tracker
    import csb_pkg::*;
#(
    parameter int          ID_WIDTH       = 1,
    parameter int          DEPTH          = 4,
    parameter int          TIMEOUT_CYCLES = 4096,
    parameter logic [31:0] ERR_DATA       = CSB_ERR_DATA
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                up_valid,
    output logic                up_ready,
    input  logic [15:0]         up_addr,
    input  logic [31:0]         up_wdat,
    input  logic                up_write,
    input  logic                up_nposted,
    input  logic [ID_WIDTH-1:0] up_id,
    output logic                csb2nvdla_valid,
    input  logic                csb2nvdla_ready,
    output logic [15:0]         csb2nvdla_addr,
    output logic [31:0]         csb2nvdla_wdat,
    output logic                csb2nvdla_write,
    output logic                csb2nvdla_nposted,
    input  logic                nvdla2csb_valid,
    input  logic [31:0]         nvdla2csb_data,
    input  logic                nvdla2csb_wr_complete,
    output logic                rsp_valid,
    output logic [31:0]         rsp_data,
    output logic [ID_WIDTH-1:0] rsp_id,
    output logic                rsp_err,
    output logic                halted_o,
    output logic                proto_err_o
);
    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic                is_write;
    } entry_t;

    localparam int               CNT_W  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               WD_EN  = (TIMEOUT_CYCLES != 0);

    trk_state_e              state;
    trk_state_e              state_nxt;
    logic                    is_run;
    csb_req_t                req;
    entry_t                  push_e;
    entry_t                  head_e;
    logic [$bits(entry_t)-1:0] head_raw;
    logic                    q_empty;
    logic                    q_full;
    logic                    needs_entry;
    logic                    blocked;
    logic                    push;
    logic                    any_rsp;
    logic                    rsp_pop;
    logic                    to_pop;
    logic                    pop;
    logic                    perr_set;
    logic [CNT_W-1:0]        wd_cnt;

    assign req = '{addr: up_addr, wdat: up_wdat, write: up_write, nposted: up_nposted};
    assign csb2nvdla_addr    = req.addr;
    assign csb2nvdla_wdat    = req.wdat;
    assign csb2nvdla_write   = req.write;
    assign csb2nvdla_nposted = req.nposted;

    assign needs_entry = ~up_write | up_nposted;
    assign any_rsp     = nvdla2csb_valid | nvdla2csb_wr_complete;
    // Responses only pop in RUN; in HALT the watchdog alone drains the queue.
    assign rsp_pop     = any_rsp & is_run & ~q_empty;
    assign to_pop      = WD_EN & ~q_empty & (wd_cnt == TO_VAL) & ~rsp_pop;
    assign pop         = rsp_pop | to_pop;

    assign blocked         = needs_entry & q_full & ~pop;
    assign csb2nvdla_valid = up_valid & is_run & ~blocked;
    assign up_ready        = csb2nvdla_ready & is_run & ~blocked;
    assign push            = up_valid & up_ready & needs_entry;
    assign push_e          = '{id: up_id, is_write: up_write};
    assign head_e          = entry_t'(head_raw);

    assign perr_set = (any_rsp & (~is_run | q_empty))
                    | (nvdla2csb_valid & nvdla2csb_wr_complete)
                    | (rsp_pop & ((nvdla2csb_valid & head_e.is_write)
                                | (nvdla2csb_wr_complete & ~head_e.is_write)));

    csb_id_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (push_e),
        .pop     (pop),
        .rd_data (head_raw),
        .empty   (q_empty),
        .full    (q_full)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= TRK_RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TRK_RUN:  if (to_pop) state_nxt = TRK_HALT;
            TRK_HALT: state_nxt = TRK_HALT;
            default:  state_nxt = TRK_RUN;
        endcase
    end

    always_comb begin
        is_run   = (state == TRK_RUN);
        halted_o = (state == TRK_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_id      <= '0;
            rsp_err     <= 1'b0;
            proto_err_o <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            rsp_valid <= pop;
            rsp_err   <= to_pop;
            rsp_id    <= pop ? head_e.id : '0;
            if (to_pop)                          rsp_data <= ERR_DATA;
            else if (rsp_pop && nvdla2csb_valid) rsp_data <= nvdla2csb_data;
            else                                 rsp_data <= '0;
            if (perr_set) proto_err_o <= 1'b1;
            wd_cnt <= (q_empty || pop) ? '0 : wd_cnt + 1'b1;
        end
    end

    a_single_strobe: assert property (@(posedge clk) disable iff (rst)
        !(nvdla2csb_valid && nvdla2csb_wr_complete));

endmodule

// File: tb/tb_csb_txn_tracker.sv
// Self-checking bench for csb_txn_tracker: directed scenarios plus a randomized
// run, all compared against a queue-based reference model of the tracker.
module tb_csb_txn_tracker;
    localparam int          IDW   = 2;
    localparam int          DEPTH = 4;
    localparam int          TMO   = 8;
    localparam logic [31:0] ERR   = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           up_valid, up_ready, up_write, up_nposted;
    logic [15:0]    up_addr;
    logic [31:0]    up_wdat;
    logic [IDW-1:0] up_id;
    logic           csb2nvdla_valid, csb2nvdla_ready, csb2nvdla_write, csb2nvdla_nposted;
    logic [15:0]    csb2nvdla_addr;
    logic [31:0]    csb2nvdla_wdat;
    logic           nvdla2csb_valid, nvdla2csb_wr_complete;
    logic [31:0]    nvdla2csb_data;
    logic           rsp_valid, rsp_err, halted_o, proto_err_o;
    logic [31:0]    rsp_data;
    logic [IDW-1:0] rsp_id;

    int checks = 0;
    int errors = 0;

    csb_txn_tracker #(
        .ID_WIDTH       (IDW),
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .ERR_DATA       (ERR)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .up_valid              (up_valid),
        .up_ready              (up_ready),
        .up_addr               (up_addr),
        .up_wdat               (up_wdat),
        .up_write              (up_write),
        .up_nposted            (up_nposted),
        .up_id                 (up_id),
        .csb2nvdla_valid       (csb2nvdla_valid),
        .csb2nvdla_ready       (csb2nvdla_ready),
        .csb2nvdla_addr        (csb2nvdla_addr),
        .csb2nvdla_wdat        (csb2nvdla_wdat),
        .csb2nvdla_write       (csb2nvdla_write),
        .csb2nvdla_nposted     (csb2nvdla_nposted),
        .nvdla2csb_valid       (nvdla2csb_valid),
        .nvdla2csb_data        (nvdla2csb_data),
        .nvdla2csb_wr_complete (nvdla2csb_wr_complete),
        .rsp_valid             (rsp_valid),
        .rsp_data              (rsp_data),
        .rsp_id                (rsp_id),
        .rsp_err               (rsp_err),
        .halted_o              (halted_o),
        .proto_err_o           (proto_err_o)
    );

    // Reference model: outstanding entries as a queue, watchdog as a wait count.
    typedef struct packed {
        logic [IDW-1:0] id;
        logic           wr;
    } ent_t;

    ent_t           m_q[$];
    int             m_wait = 0;
    bit             m_halt = 0, m_perr = 0, m_rv = 0, m_rerr = 0;
    logic [31:0]    m_rd = '0;
    logic [IDW-1:0] m_rid = '0;

    function automatic bit m_any();
        return nvdla2csb_valid || nvdla2csb_wr_complete;
    endfunction

    function automatic bit m_timeout();
        return (m_q.size() != 0) && (m_wait == TMO) && (m_halt || !m_any());
    endfunction

    function automatic bit m_pop();
        return (m_any() && !m_halt && m_q.size() != 0) || m_timeout();
    endfunction

    function automatic bit m_gate();
        bit needs;
        needs = !up_write || up_nposted;
        return !m_halt && !(needs && m_q.size() == DEPTH && !m_pop());
    endfunction

    task automatic tick();
        bit          any, tmo, pop, acc, was_empty, nvv, nvw;
        logic [31:0] nvd;
        ent_t        head;
        any       = m_any();
        tmo       = m_timeout();
        pop       = m_pop();
        acc       = up_valid && csb2nvdla_ready && m_gate() && (!up_write || up_nposted);
        was_empty = (m_q.size() == 0);
        head      = was_empty ? '0 : m_q[0];
        nvv       = nvdla2csb_valid;
        nvw       = nvdla2csb_wr_complete;
        nvd       = nvdla2csb_data;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_wait = 0; m_halt = 0; m_perr = 0; m_rv = 0; m_rerr = 0; m_rd = '0; m_rid = '0;
        end else begin
            if (any && (m_halt || was_empty)) m_perr = 1;
            if (pop && !tmo && ((nvv && head.wr) || (nvw && !head.wr))) m_perr = 1;
            m_rv   = pop;
            m_rerr = tmo;
            m_rid  = head.id;
            m_rd   = tmo ? ERR : (nvv ? nvd : 32'h0);
            if (pop) void'(m_q.pop_front());
            if (tmo) m_halt = 1;
            if (was_empty || pop) m_wait = 0;
            else                  m_wait++;
            if (acc) m_q.push_back('{id: up_id, wr: up_write});
        end
        #1;
    endtask

    task automatic set_idle();
        up_valid = 0; up_write = 0; up_nposted = 0; up_id = '0; up_addr = '0; up_wdat = '0;
        csb2nvdla_ready = 1; nvdla2csb_valid = 0; nvdla2csb_wr_complete = 0; nvdla2csb_data = '0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
        checks++; if (rsp_id !== '0) begin errors++; $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
        checks++; if (halted_o !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted_o); end
        checks++; if (proto_err_o !== 1'b0) begin errors++; $display("FAIL reset_proto_err got %b exp 0", proto_err_o); end
        #2;
        checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL reset_up_ready got %b exp 1", up_ready); end
    endtask

    task automatic test_read();
        do_reset();
        up_valid = 1; up_write = 0; up_id = 2'd1; up_addr = 16'h0010;
        #2;
        checks++; if (csb2nvdla_valid !== 1'b1 || up_ready !== 1'b1) begin errors++; $display("FAIL read_handshake got v=%b r=%b exp 1 1", csb2nvdla_valid, up_ready); end
        checks++; if (csb2nvdla_addr !== 16'h0010 || csb2nvdla_write !== 1'b0) begin errors++; $display("FAIL read_fwd got addr=%h wr=%b exp 0010 0", csb2nvdla_addr, csb2nvdla_write); end
        tick();
        set_idle();
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL read_early_rsp got %b exp 0", rsp_valid); end
        nvdla2csb_valid = 1; nvdla2csb_data = 32'h1234_5678;
        tick();
        set_idle();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_err !== 1'b0) begin errors++; $display("FAIL read_rsp got v=%b id=%0d err=%b exp 1 1 0", rsp_valid, rsp_id, rsp_err); end
        checks++; if (rsp_data !== 32'h1234_5678) begin errors++; $display("FAIL read_rsp_data got %h exp 12345678", rsp_data); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || proto_err_o !== 1'b0) begin errors++; $display("FAIL read_after got v=%b perr=%b exp 0 0", rsp_valid, proto_err_o); end
    endtask

    task automatic test_back_to_back_writes();
        int          ids[4] = '{0, 1, 0, 1};
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            up_valid = 1; up_write = 1; up_nposted = 1; up_id = IDW'(ids[i]); up_addr = 16'(i); up_wdat = $urandom;
            #2;
            checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d] got %b exp 1", i, up_ready); end
            tick();
        end
        up_write = 0; up_nposted = 0; up_id = 2'd2;
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++; if (up_ready !== 1'b0 || csb2nvdla_valid !== 1'b0) begin errors++; $display("FAIL full_block[%0d] got r=%b v=%b exp 0 0", i, up_ready, csb2nvdla_valid); end
            tick();
        end
        nvdla2csb_wr_complete = 1;
        #2;
        checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL full_push_pop got %b exp 1", up_ready); end
        tick();
        up_valid = 0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== IDW'(ids[i]) || rsp_data !== 32'h0) begin errors++; $display("FAIL wr_rsp[%0d] got v=%b id=%0d d=%h exp 1 %0d 0", i, rsp_valid, rsp_id, rsp_data, ids[i]); end
            if (i < 3) tick();
        end
        d = $urandom;
        nvdla2csb_wr_complete = 0; nvdla2csb_valid = 1; nvdla2csb_data = d;
        tick();
        set_idle();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== d) begin errors++; $display("FAIL fifth_rsp got v=%b id=%0d d=%h exp 1 2 %h", rsp_valid, rsp_id, rsp_data, d); end
        checks++; if (proto_err_o !== 1'b0) begin errors++; $display("FAIL fifth_perr got %b exp 0", proto_err_o); end
    endtask

    task automatic test_posted_full();
        bit rdy[3] = '{1, 0, 1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            up_valid = 1; up_write = 0; up_id = 2'd3; up_addr = 16'h100 + 16'(i);
            tick();
        end
        up_write = 1; up_nposted = 0;
        for (int i = 0; i < 3; i++) begin
            csb2nvdla_ready = rdy[i];
            #2;
            checks++; if (up_ready !== rdy[i] || csb2nvdla_valid !== 1'b1) begin errors++; $display("FAIL posted_full[%0d] got r=%b v=%b exp %b 1", i, up_ready, csb2nvdla_valid, rdy[i]); end
            tick();
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL posted_no_rsp[%0d] got %b exp 0", i, rsp_valid); end
        end
        set_idle();
        for (int i = 0; i < 5; i++) begin
            nvdla2csb_valid = 1; nvdla2csb_data = 32'hA000_0000 + 32'(i);
            tick();
            checks++; if (rsp_valid !== (i < 4)) begin errors++; $display("FAIL posted_drain[%0d] got %b exp %b", i, rsp_valid, (i < 4)); end
        end
        set_idle();
        checks++; if (proto_err_o !== 1'b1) begin errors++; $display("FAIL posted_extra_perr got %b exp 1", proto_err_o); end
    endtask

    task automatic test_empty_wr_complete();
        do_reset();
        nvdla2csb_wr_complete = 1;
        tick();
        nvdla2csb_wr_complete = 0;
        checks++; if (rsp_valid !== 1'b0 || proto_err_o !== 1'b1) begin errors++; $display("FAIL empty_wc got v=%b perr=%b exp 0 1", rsp_valid, proto_err_o); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || proto_err_o !== 1'b1) begin errors++; $display("FAIL empty_wc_sticky got v=%b perr=%b exp 0 1", rsp_valid, proto_err_o); end
    endtask

    task automatic test_timeout();
        int t_first = -1, t_second = -1, n_err = 0;
        do_reset();
        up_valid = 1; up_write = 0; up_id = 2'd1;
        tick();
        for (int t = 1; t <= 24; t++) begin
            set_idle();
            if (t == 1) begin up_valid = 1; up_id = 2'd2; end
            if (t >= 10) begin up_valid = 1; up_write = $urandom_range(1); up_nposted = 1; end
            if (t == 12) begin nvdla2csb_valid = 1; nvdla2csb_data = 32'h5555_AAAA; end
            if (t >= 10) begin
                #2;
                checks++; if (up_ready !== 1'b0 || csb2nvdla_valid !== 1'b0) begin errors++; $display("FAIL halt_block t=%0d got r=%b v=%b exp 0 0", t, up_ready, csb2nvdla_valid); end
            end
            tick();
            checks++; if (rsp_valid !== m_rv) begin errors++; $display("FAIL to_rsp_valid t=%0d got %b exp %b", t, rsp_valid, m_rv); end
            if (rsp_valid === 1'b1 && rsp_err === 1'b1) begin
                n_err++;
                if (t_first < 0) t_first = t; else t_second = t;
                checks++; if (rsp_data !== ERR || halted_o !== 1'b1) begin errors++; $display("FAIL to_reply t=%0d got d=%h h=%b exp %h 1", t, rsp_data, halted_o, ERR); end
                checks++; if (rsp_id !== IDW'(n_err)) begin errors++; $display("FAIL to_reply_id t=%0d got %0d exp %0d", t, rsp_id, n_err); end
            end
            if (t == 12) begin
                checks++; if (proto_err_o !== 1'b1) begin errors++; $display("FAIL halt_late_perr got %b exp 1", proto_err_o); end
            end
        end
        set_idle();
        checks++; if (t_first !== 9 || t_second !== 18 || n_err !== 2) begin errors++; $display("FAIL to_timing got first=%0d second=%0d n=%0d exp 9 18 2", t_first, t_second, n_err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            up_valid = 1; up_write = 0; up_id = IDW'(i);
            tick();
        end
        set_idle();
        rst = 1;
        tick();
        rst = 0;
        checks++; if ({rsp_valid, rsp_err, halted_o, proto_err_o} !== 4'b0 || rsp_data !== 32'h0 || rsp_id !== '0) begin errors++; $display("FAIL rstmid_outs got v=%b e=%b h=%b p=%b d=%h id=%0d exp all 0", rsp_valid, rsp_err, halted_o, proto_err_o, rsp_data, rsp_id); end
        #2;
        checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", up_ready); end
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale[%0d] got %b exp 0", i, rsp_valid); end
        end
        nvdla2csb_valid = 1;
        tick();
        set_idle();
        checks++; if (rsp_valid !== 1'b0 || proto_err_o !== 1'b1) begin errors++; $display("FAIL rstmid_late got v=%b p=%b exp 0 1", rsp_valid, proto_err_o); end
    endtask

    task automatic test_random();
        bit exp_r, exp_v, kind;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            set_idle();
            rst = ((c % 150) == 149);
            up_valid = ($urandom_range(1) == 1);
            up_write = ($urandom_range(1) == 1);
            up_nposted = ($urandom_range(1) == 1);
            up_id = IDW'($urandom);
            up_addr = 16'($urandom);
            up_wdat = $urandom;
            csb2nvdla_ready = ($urandom_range(3) != 0);
            nvdla2csb_data = $urandom;
            if (m_q.size() != 0 && !m_halt && $urandom_range(9) < 4) begin
                kind = m_q[0].wr;
                if ($urandom_range(19) == 0) kind = !kind;
                if (kind) nvdla2csb_wr_complete = 1; else nvdla2csb_valid = 1;
            end else if ($urandom_range(39) == 0) begin
                nvdla2csb_wr_complete = 1;
            end
            #2;
            if (!rst) begin
                exp_r = csb2nvdla_ready && m_gate();
                exp_v = up_valid && m_gate();
                checks++; if (up_ready !== exp_r) begin errors++; $display("FAIL rnd_up_ready c=%0d got %b exp %b", c, up_ready, exp_r); end
                checks++; if (csb2nvdla_valid !== exp_v) begin errors++; $display("FAIL rnd_fwd_valid c=%0d got %b exp %b", c, csb2nvdla_valid, exp_v); end
                checks++; if (csb2nvdla_addr !== up_addr || csb2nvdla_wdat !== up_wdat || csb2nvdla_write !== up_write || csb2nvdla_nposted !== up_nposted) begin errors++; $display("FAIL rnd_passthru c=%0d got %h/%h/%b/%b", c, csb2nvdla_addr, csb2nvdla_wdat, csb2nvdla_write, csb2nvdla_nposted); end
            end
            tick();
            checks++; if (rsp_valid !== m_rv) begin errors++; $display("FAIL rnd_rsp_valid c=%0d got %b exp %b", c, rsp_valid, m_rv); end
            if (m_rv) begin
                checks++; if (rsp_id !== m_rid || rsp_data !== m_rd || rsp_err !== m_rerr) begin errors++; $display("FAIL rnd_rsp c=%0d got id=%0d d=%h e=%b exp %0d %h %b", c, rsp_id, rsp_data, rsp_err, m_rid, m_rd, m_rerr); end
            end
            checks++; if (halted_o !== m_halt || proto_err_o !== m_perr) begin errors++; $display("FAIL rnd_flags c=%0d got h=%b p=%b exp %b %b", c, halted_o, proto_err_o, m_halt, m_perr); end
        end
        rst = 0;
        set_idle();
    endtask

    initial begin
        rst = 1;
        set_idle();
        test_reset();
        test_read();
        test_back_to_back_writes();
        test_posted_full();
        test_empty_wr_complete();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
